// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: owner FSM encoding,
// requester IDs and default bus widths.
package dm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_HOST = 1'b1;

   localparam int DEF_AW  = 8;
   localparam int DEF_WDW = 16;
   localparam int DEF_RDW = 8;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag pipeline: carries {valid, requester id} alongside the
// data_mem read latency so returning data can be steered to its owner.
module rd_tag_pipe #(
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vld_p0,
   input  logic id_p0,
   output logic vld_out,
   output logic id_out
);

   logic [RD_LAT-1:0] vld_pn;
   logic [RD_LAT-1:0] id_pn;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pn <= '0;
         id_pn  <= '0;
      end else begin
         vld_pn[0] <= vld_p0;
         id_pn[0]  <= id_p0;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pn[i] <= vld_pn[i-1];
            id_pn[i]  <= id_pn[i-1];
         end
      end
   end

   assign vld_out = vld_pn[RD_LAT-1];
   assign id_out  = id_pn[RD_LAT-1];

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single data_mem port between the core (port 0) and the host
// loader (port 1): registered owner FSM, round-robin with a burst cap.
module dm_port_arbiter
   import dm_arb_pkg::*;
#(
   parameter int AW        = DEF_AW,
   parameter int WDW       = DEF_WDW,
   parameter int RDW       = DEF_RDW,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0,
   input  logic           req1,
   input  logic           we0,
   input  logic           we1,
   input  logic [AW-1:0]  addr0,
   input  logic [AW-1:0]  addr1,
   input  logic [WDW-1:0] wdata0,
   input  logic [WDW-1:0] wdata1,
   output logic           gnt0,
   output logic           gnt1,
   output logic           rvalid0,
   output logic           rvalid1,
   output logic [RDW-1:0] rdata,
   output logic           mem_we,
   output logic [AW-1:0]  mem_addr,
   output logic [WDW-1:0] mem_wdata,
   input  logic [RDW-1:0] mem_rdata
);

   localparam int            CW  = $clog2(MAX_BURST) + 1;
   localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

   arb_state_e     state;
   arb_state_e     oth_state;
   logic           last;
   logic [CW-1:0]  burst_cnt;
   logic [AW-1:0]  addr_q;
   logic [WDW-1:0] wdata_q;

   logic           own1;
   logic           own_req;
   logic           oth_req;
   logic           own_we;
   logic [AW-1:0]  own_addr;
   logic [WDW-1:0] own_wdata;
   logic           gnt_any;
   logic           rd_vld;
   logic           rd_id;

   // Owner/other views are only meaningful in OWN0/OWN1; IDLE never grants.
   assign own1      = (state == OWN1);
   assign own_req   = own1 ? req1   : req0;
   assign oth_req   = own1 ? req0   : req1;
   assign own_we    = own1 ? we1    : we0;
   assign own_addr  = own1 ? addr1  : addr0;
   assign own_wdata = own1 ? wdata1 : wdata0;

   always_comb begin
      oth_state = OWN1;
      if (own1) oth_state = OWN0;
   end

   assign gnt0    = (state == OWN0) & req0;
   assign gnt1    = (state == OWN1) & req1;
   assign gnt_any = gnt0 | gnt1;

   assign mem_we    = gnt_any & own_we;
   assign mem_addr  = gnt_any ? own_addr  : addr_q;
   assign mem_wdata = gnt_any ? own_wdata : wdata_q;

   // Owner FSM; burst_cnt restarts on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= PORT_HOST;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               burst_cnt <= '0;
               if (req0 && req1) begin
                  if (last == PORT_HOST) state <= OWN0;
                  else                   state <= OWN1;
               end else if (req0) begin
                  state <= OWN0;
               end else if (req1) begin
                  state <= OWN1;
               end
            end
            OWN0, OWN1: begin
               if (!own_req || (oth_req && burst_cnt == CAP)) begin
                  state     <= oth_req ? oth_state : IDLE;
                  last      <= own1;
                  burst_cnt <= '0;
               end else if (oth_req) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               burst_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (gnt_any) begin
         addr_q  <= own_addr;
         wdata_q <= own_wdata;
      end
   end

   rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .vld_p0  (gnt_any & ~own_we),
      .id_p0   (own1),
      .vld_out (rd_vld),
      .id_out  (rd_id)
   );

   assign rvalid0 = rd_vld & ~rd_id;
   assign rvalid1 = rd_vld &  rd_id;
   assign rdata   = mem_rdata;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed and randomised checks of the data-memory port arbiter against a
// small behavioural data_mem and a shadow-memory scoreboard.
module tb_dm_port_arbiter;

   localparam int AW        = 8;
   localparam int WDW       = 16;
   localparam int RDW       = 8;
   localparam int RD_LAT    = 1;
   localparam int MAX_BURST = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [AW-1:0]  addr0 = '0, addr1 = '0;
   logic [WDW-1:0] wdata0 = '0, wdata1 = '0;
   logic           gnt0, gnt1, rvalid0, rvalid1, mem_we;
   logic [RDW-1:0] rdata;
   logic [AW-1:0]  mem_addr;
   logic [WDW-1:0] mem_wdata;
   logic [RDW-1:0] mem_rdata;

   logic [7:0]     mem [256];
   logic [7:0]     shadow [256];
   logic           clr_mem = 1'b1;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       id;
      logic [7:0] data;
      int         due;
   } rd_exp_t;
   rd_exp_t rq[$];

   always #5 clk = ~clk;

   dm_port_arbiter #(
      .AW(AW), .WDW(WDW), .RDW(RDW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Behavioural data_mem: low byte stored, one-cycle registered read.
   always @(posedge clk) begin
      if (clr_mem) begin
         for (int a = 0; a < 256; a++) mem[a] <= 8'h00;
         mem_rdata <= 8'h00;
      end else begin
         if (mem_we) mem[mem_addr] <= mem_wdata[7:0];
         mem_rdata <= mem[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wr0(input logic [7:0] a, input logic [15:0] d);
      int n;
      n = 0;
      req0 = 1'b1; we0 = 1'b1; addr0 = a; wdata0 = d;
      #1;
      while (!gnt0 && n < 8) begin
         tick();
         #1;
         n++;
      end
      check("wr0_gnt", gnt0, 1);
      tick();
      req0 = 1'b0; we0 = 1'b0;
   endtask

   task automatic chk_rret(input int c);
      logic ev0, ev1;
      ev0 = 1'b0; ev1 = 1'b0;
      if (rq.size() > 0 && rq[0].due == c) begin
         if (rq[0].id) ev1 = 1'b1;
         else          ev0 = 1'b1;
      end
      check("r_rvalid0", rvalid0, ev0);
      check("r_rvalid1", rvalid1, ev1);
      if (ev0 || ev1) begin
         check("r_rdata", rdata, rq[0].data);
         void'(rq.pop_front());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         pend [2];
      logic       pwe  [2];
      logic [7:0] pad  [2];
      logic [15:0] pwd [2];
      int         waitc [2];
      int         nbad;
      int         c;
      logic       gp;

      // Reset state
      #2;
      check("rst_gnt", {gnt1, gnt0}, 2'b00);
      check("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      tick();
      tick();
      clr_mem = 1'b0;
      rst_n = 1'b1;

      // 1: port 0 alone, write then read back
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 16'h00AB;
      #1;
      check("t1_idle_gnt0", gnt0, 0);
      tick(); #1;
      check("t1_wr_gnt0", gnt0, 1);
      check("t1_wr_gnt1", gnt1, 0);
      check("t1_wr_we", mem_we, 1);
      check("t1_wr_addr", mem_addr, 8'h10);
      check("t1_wr_wdata", mem_wdata, 16'h00AB);
      tick();
      we0 = 1'b0;
      #1;
      check("t1_rd_gnt0", gnt0, 1);
      check("t1_rd_we", mem_we, 0);
      check("t1_rd_addr", mem_addr, 8'h10);
      check("t1_rd_rvalid0_early", rvalid0, 0);
      tick();
      req0 = 1'b0;
      #1;
      check("t1_rvalid0", rvalid0, 1);
      check("t1_rvalid1", rvalid1, 0);
      check("t1_rdata", rdata, 8'hAB);
      check("t1_no_gnt", {gnt1, gnt0}, 2'b00);
      tick();
      #1;
      check("t1_rvalid_done", {rvalid1, rvalid0}, 2'b00);
      tick();

      // 2: simultaneous request after reset -> port 0 first, handoff on drop
      do_reset();
      req0 = 1'b1; req1 = 1'b1; addr0 = 8'h10; addr1 = 8'h11;
      #1;
      check("t2_idle", {gnt1, gnt0}, 2'b00);
      tick(); #1;
      check("t2_own0", {gnt1, gnt0}, 2'b01);
      tick();
      req0 = 1'b0;
      #1;
      check("t2_drop", {gnt1, gnt0}, 2'b00);
      tick(); #1;
      check("t2_own1", {gnt1, gnt0}, 2'b10);
      tick();
      req1 = 1'b0;
      tick();
      tick();

      // 3: both held -> alternating MAX_BURST-beat bursts
      do_reset();
      req0 = 1'b1; req1 = 1'b1; addr0 = 8'h30; addr1 = 8'h31;
      tick();
      for (int k = 0; k < 4 * MAX_BURST; k++) begin
         #1;
         check("t3_gnt0", gnt0, ((k / MAX_BURST) % 2) == 0);
         check("t3_gnt1", gnt1, ((k / MAX_BURST) % 2) == 1);
         tick();
      end
      idle_inputs();
      tick();
      tick();

      // 4: tagged read return across a forced handoff
      do_reset();
      wr0(8'h1E, 16'h005A);
      wr0(8'h1F, 16'h005B);
      wr0(8'h20, 16'h0001);
      wr0(8'h21, 16'h0002);
      wr0(8'h22, 16'h0003);
      tick();
      do_reset();
      req1 = 1'b1; addr1 = 8'h1E;
      #1;
      check("t4_idle", gnt1, 0);
      tick();
      req0 = 1'b1; addr0 = 8'h22;
      #1;
      check("t4_b1", {gnt1, gnt0}, 2'b10);
      check("t4_b1_addr", mem_addr, 8'h1E);
      tick();
      addr1 = 8'h1F;
      #1;
      check("t4_b2", {gnt1, gnt0}, 2'b10);
      check("t4_rv_5a", {rvalid1, rvalid0, rdata}, {2'b10, 8'h5A});
      tick();
      addr1 = 8'h20;
      #1;
      check("t4_b3", {gnt1, gnt0}, 2'b10);
      check("t4_rv_5b", {rvalid1, rvalid0, rdata}, {2'b10, 8'h5B});
      tick();
      addr1 = 8'h21;
      #1;
      check("t4_b4", {gnt1, gnt0}, 2'b10);
      check("t4_b4_addr", mem_addr, 8'h21);
      check("t4_rv_1", {rvalid1, rvalid0, rdata}, {2'b10, 8'h01});
      tick();
      req1 = 1'b0;
      #1;
      check("t4_handoff", {gnt1, gnt0}, 2'b01);
      check("t4_h_addr", mem_addr, 8'h22);
      check("t4_rv_2", {rvalid1, rvalid0, rdata}, {2'b10, 8'h02});
      tick();
      req0 = 1'b0;
      #1;
      check("t4_rv_3", {rvalid1, rvalid0, rdata}, {2'b01, 8'h03});
      tick();

      // 5: reset while a read is in flight
      do_reset();
      req0 = 1'b1; addr0 = 8'h22;
      #1;
      check("t5_idle", gnt0, 0);
      tick(); #1;
      check("t5_gnt", gnt0, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("t5_async_gnt", {gnt1, gnt0}, 2'b00);
      check("t5_async_we", mem_we, 0);
      check("t5_async_addr", mem_addr, 0);
      check("t5_async_wdata", mem_wdata, 0);
      check("t5_async_rv", {rvalid1, rvalid0}, 2'b00);
      for (int k = 0; k < 3; k++) begin
         tick(); #1;
         check("t5_no_rv", {rvalid1, rvalid0}, 2'b00);
      end
      rst_n = 1'b1;
      #1;
      check("t5_post_idle", gnt0, 0);
      tick(); #1;
      check("t5_post_gnt", gnt0, 1);
      tick();
      req0 = 1'b0;
      #1;
      check("t5_post_rv", {rvalid0, rdata}, {1'b1, 8'h03});
      tick();

      // 6: random traffic against shadow memory and read scoreboard
      do_reset();
      for (int a = 0; a < 256; a++) shadow[a] = mem[a];
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0; pwe[p] = 1'b0; pad[p] = '0; pwd[p] = '0; waitc[p] = 0;
      end
      c = 0;
      for (int cy = 0; cy < 3000; cy++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 3) != 0) begin
               pend[p]  = 1'b1;
               pwe[p]   = 1'($urandom_range(0, 1));
               pad[p]   = 8'($urandom_range(0, 15));
               pwd[p]   = 16'($urandom);
               waitc[p] = 0;
            end
         end
         req0 = pend[0]; we0 = pwe[0]; addr0 = pad[0]; wdata0 = pwd[0];
         req1 = pend[1]; we1 = pwe[1]; addr1 = pad[1]; wdata1 = pwd[1];
         #1;
         check("r_excl", gnt0 & gnt1, 0);
         chk_rret(c);
         if (!(gnt0 || gnt1)) check("r_nowe", mem_we, 0);
         for (int p = 0; p < 2; p++) begin
            gp = (p == 0) ? gnt0 : gnt1;
            if (pend[p] && gp) begin
               check("r_addr", mem_addr, pad[p]);
               check("r_we", mem_we, pwe[p]);
               if (pwe[p]) begin
                  check("r_wdata", mem_wdata, pwd[p]);
                  shadow[pad[p]] = pwd[p][7:0];
               end else begin
                  rq.push_back('{id: 1'(p), data: shadow[pad[p]], due: c + RD_LAT});
               end
               check("r_wait", waitc[p] <= MAX_BURST + 1, 1);
               pend[p] = 1'b0;
            end else if (pend[p]) begin
               waitc[p]++;
               if (waitc[p] == MAX_BURST + 2) check("r_starve", waitc[p], MAX_BURST + 1);
            end else begin
               check("r_gnt_noreq", gp, 0);
            end
         end
         tick();
         c++;
      end
      idle_inputs();
      for (int k = 0; k < RD_LAT + 2; k++) begin
         #1;
         chk_rret(c);
         tick();
         c++;
      end
      check("r_queue_empty", rq.size(), 0);
      nbad = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== shadow[a]) nbad++;
      check("r_mem_contents", nbad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
